// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle processor control FSM: opcodes, states,
// and the select/op-class codes driven onto the datapath.
package multicycle_ctrl_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath: Moore-decoded strobes and selects,
// with memory-step enables qualified by MemReady and PCEn qualified by Zero.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int ALUOP_WIDTH = 2,
    parameter int PCSRC_WIDTH = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [OP_WIDTH-1:0]    Opcode,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   PCEn,
    output logic                   IRWrite,
    output logic                   MDRWrite,
    output logic                   ABWrite,
    output logic                   ALUOutWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [PCSRC_WIDTH-1:0] PCSource,
    output logic                   IllegalOp
);

    state_t state_reg, state_next;
    logic   pcwrite, pcwritecond;

    // Reset forces S_RESET immediately, so every strobe drops without a clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= S_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        ABWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        IllegalOp   = 1'b0;

        case (state_reg)
            S_RESET: state_next = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                ABWrite     = 1'b1;
                ALUOutWrite = 1'b1;
                ALUSrcB     = SRCB_IMM_SH;
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default: begin
                        IllegalOp  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOutWrite = 1'b1;
                state_next  = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) begin
                    MDRWrite   = 1'b1;
                    state_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end

            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_next = S_FETCH;
                end
            end

            S_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_FUNCT;
                ALUOutWrite = 1'b1;
                state_next  = S_ALUWB;
            end

            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCSource    = PCSRC_ALUOUT;
                pcwritecond = 1'b1;
                state_next  = S_FETCH;
            end

            S_JUMP: begin
                pcwrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                state_next = S_FETCH;
            end

            S_ADDI_EX: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOutWrite = 1'b1;
                state_next  = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end

            default: state_next = S_RESET;
        endcase
    end

    assign PCEn = pcwrite | (pcwritecond & Zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for multicycle_ctrl: a table of {inputs, expected
// outputs} per cycle, checked through a scoreboard queue, plus an async-reset abort.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCEn, IRWrite, MDRWrite, ABWrite, ALUOutWrite, IorD;
    logic       MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       IllegalOp;

    multicycle_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IRWrite(IRWrite), .MDRWrite(MDRWrite), .ABWrite(ABWrite),
        .ALUOutWrite(ALUOutWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    // Output bundle: {PCEn,IRWrite,MDRWrite,ABWrite,ALUOutWrite,IorD,MemRead,MemWrite,
    //                 MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    localparam logic [18:0] B_PCEN = 19'h1 << 18;
    localparam logic [18:0] B_IRW  = 19'h1 << 17;
    localparam logic [18:0] B_MDRW = 19'h1 << 16;
    localparam logic [18:0] B_ABW  = 19'h1 << 15;
    localparam logic [18:0] B_AOW  = 19'h1 << 14;
    localparam logic [18:0] B_IORD = 19'h1 << 13;
    localparam logic [18:0] B_MRD  = 19'h1 << 12;
    localparam logic [18:0] B_MWR  = 19'h1 << 11;
    localparam logic [18:0] B_M2R  = 19'h1 << 10;
    localparam logic [18:0] B_RD   = 19'h1 << 9;
    localparam logic [18:0] B_RW   = 19'h1 << 8;
    localparam logic [18:0] B_SRCA = 19'h1 << 7;
    localparam logic [18:0] SB_4   = 19'h1 << 5;
    localparam logic [18:0] SB_IMM = 19'h2 << 5;
    localparam logic [18:0] SB_SH  = 19'h3 << 5;
    localparam logic [18:0] AO_SUB = 19'h1 << 3;
    localparam logic [18:0] AO_FN  = 19'h2 << 3;
    localparam logic [18:0] PC_AO  = 19'h1 << 1;
    localparam logic [18:0] PC_J   = 19'h2 << 1;
    localparam logic [18:0] B_ILL  = 19'h1;

    localparam logic [18:0] E_ZERO    = 19'h0;
    localparam logic [18:0] E_FETCH   = B_PCEN | B_IRW | B_MRD | SB_4;
    localparam logic [18:0] E_FETCH_W = B_MRD | SB_4;
    localparam logic [18:0] E_DECODE  = B_ABW | B_AOW | SB_SH;
    localparam logic [18:0] E_DEC_ILL = B_ABW | B_AOW | SB_SH | B_ILL;
    localparam logic [18:0] E_MEMADR  = B_SRCA | SB_IMM | B_AOW;
    localparam logic [18:0] E_MEMRD   = B_IORD | B_MRD | B_MDRW;
    localparam logic [18:0] E_MEMRD_W = B_IORD | B_MRD;
    localparam logic [18:0] E_MEMWB   = B_M2R | B_RW;
    localparam logic [18:0] E_MEMWR   = B_IORD | B_MWR;
    localparam logic [18:0] E_EXEC    = B_SRCA | AO_FN | B_AOW;
    localparam logic [18:0] E_ALUWB   = B_RD | B_RW;
    localparam logic [18:0] E_BR_T    = B_PCEN | B_SRCA | AO_SUB | PC_AO;
    localparam logic [18:0] E_BR_N    = B_SRCA | AO_SUB | PC_AO;
    localparam logic [18:0] E_JUMP    = B_PCEN | PC_J;
    localparam logic [18:0] E_ADDIWB  = B_RW;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [18:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] sb_q[$];
    int          id_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [18:0] pack_out();
        return {PCEn, IRWrite, MDRWrite, ABWrite, ALUOutWrite, IorD, MemRead, MemWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check_out();
        logic [18:0] got, want;
        int          id;
        got  = pack_out();
        want = sb_q.pop_front();
        id   = id_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d outputs got %05h want %05h", id, got, want);
        end else begin
            $display("step%0d ok outputs %05h", id, got);
        end
    endtask

    task automatic step(input vec_t v, input int id);
        @(negedge Clk);
        Reset = v.rst; Opcode = v.op; Zero = v.z; MemReady = v.mr;
        sb_q.push_back(v.exp);
        id_q.push_back(id);
        #1;
        check_out();
    endtask

    initial begin
        // Reset held, then released: S_RESET for one cycle
        repeat (3) add(1, OP_LW, 0, 1, E_ZERO);
        add(0, OP_LW, 0, 1, E_ZERO);
        // LW, no waits; MemReady low outside memory states has no effect
        add(0, OP_LW, 0, 1, E_FETCH);
        add(0, OP_LW, 0, 0, E_DECODE);
        add(0, OP_LW, 0, 0, E_MEMADR);
        add(0, OP_LW, 0, 1, E_MEMRD);
        add(0, OP_LW, 1, 0, E_MEMWB);
        // LW with three wait cycles in MEMREAD
        add(0, OP_LW, 0, 1, E_FETCH);
        add(0, OP_LW, 0, 0, E_DECODE);
        add(0, OP_LW, 0, 0, E_MEMADR);
        repeat (3) add(0, OP_LW, 0, 0, E_MEMRD_W);
        add(0, OP_LW, 0, 1, E_MEMRD);
        add(0, OP_LW, 0, 0, E_MEMWB);
        // BEQ taken, then not taken
        add(0, OP_BEQ, 0, 1, E_FETCH);
        add(0, OP_BEQ, 0, 1, E_DECODE);
        add(0, OP_BEQ, 1, 1, E_BR_T);
        add(0, OP_BEQ, 1, 1, E_FETCH);
        add(0, OP_BEQ, 1, 1, E_DECODE);
        add(0, OP_BEQ, 0, 1, E_BR_N);
        // Illegal opcode, then a stalled fetch
        add(0, 6'h3F, 0, 1, E_FETCH);
        add(0, 6'h3F, 1, 1, E_DEC_ILL);
        add(0, 6'h3F, 1, 0, E_FETCH_W);
        // R-type with Zero high in ALUWB (PCEn must stay low)
        add(0, OP_RTYPE, 0, 1, E_FETCH);
        add(0, OP_RTYPE, 0, 1, E_DECODE);
        add(0, OP_RTYPE, 0, 1, E_EXEC);
        add(0, OP_RTYPE, 1, 1, E_ALUWB);
        // ADDI
        add(0, OP_ADDI, 0, 1, E_FETCH);
        add(0, OP_ADDI, 0, 1, E_DECODE);
        add(0, OP_ADDI, 0, 1, E_MEMADR);
        add(0, OP_ADDI, 0, 1, E_ADDIWB);
        // J
        add(0, OP_J, 0, 1, E_FETCH);
        add(0, OP_J, 0, 1, E_DECODE);
        add(0, OP_J, 0, 1, E_JUMP);
        // SW with one wait cycle
        add(0, OP_SW, 0, 1, E_FETCH);
        add(0, OP_SW, 0, 1, E_DECODE);
        add(0, OP_SW, 0, 1, E_MEMADR);
        add(0, OP_SW, 0, 0, E_MEMWR);
        add(0, OP_SW, 0, 1, E_MEMWR);
        add(0, OP_SW, 0, 1, E_FETCH);
        // SW stalled in MEMWRITE, to be aborted by an async reset
        add(0, OP_SW, 0, 1, E_DECODE);
        add(0, OP_SW, 0, 1, E_MEMADR);
        add(0, OP_SW, 0, 0, E_MEMWR);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Mid-cycle reset pulse: strobes must drop before the next edge
        #2;
        Reset = 1'b1;
        sb_q.push_back(E_ZERO);
        id_q.push_back(900);
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL async_reset MemWrite got %b want 0", MemWrite);
        end else begin
            $display("async_reset ok MemWrite 0");
        end
        check_out();

        begin
            vec_t v;
            v.op = OP_SW; v.z = 0; v.mr = 0;
            v.rst = 1; v.exp = E_ZERO;    step(v, 901);
            v.rst = 0; v.exp = E_ZERO;    step(v, 902);
            v.rst = 0; v.exp = E_FETCH_W; step(v, 903);
            v.mr  = 1; v.exp = E_FETCH;   step(v, 904);
            v.exp = E_DECODE;             step(v, 905);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
